time_display: RTL and testbench

TIME_DISPLAY -- requirements
Module: time_display

---
 rtl/time_display.sv | 140 ++++++++++++++
 tb/tb_time_display.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/time_display.sv
// Eight-digit multiplexed status display: two time values, wash program and water level.
// Optional build macro TIME_DISPLAY_BLINK_EN blinks the time digits while paused.
module time_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_sec,
  input  logic       power_led,
  input  logic       start_led,
  input  logic [2:0] model_now,
  input  logic [3:0] water_level,
  input  logic [5:0] time_now,
  input  logic [5:0] time_all,
  output logic [7:0] an,
  output logic [7:0] seg
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [2:0]    digit_idx;
  logic          wrap;
  logic          power_q;
  logic          load_snap;
  logic [5:0]    snap_all;
  logic [5:0]    snap_now;
  logic [2:0]    snap_model;
  logic [3:0]    snap_water;
  logic [7:0]    next_an;
  logic [7:0]    next_seg;
  logic [7:0]    an_q;
  logic [7:0]    seg_q;

  assign wrap      = (div_cnt == DW'(SCAN_DIV - 1));
  assign load_snap = (wrap && (digit_idx == 3'd7)) || (power_led && !power_q);

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'h3F;
      4'd1:    seg_code = 8'h06;
      4'd2:    seg_code = 8'h5B;
      4'd3:    seg_code = 8'h4F;
      4'd4:    seg_code = 8'h66;
      4'd5:    seg_code = 8'h6D;
      4'd6:    seg_code = 8'h7D;
      4'd7:    seg_code = 8'h07;
      4'd8:    seg_code = 8'h7F;
      4'd9:    seg_code = 8'h6F;
      default: seg_code = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      digit_idx <= 3'd0;
    end else if (wrap) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      div_cnt   <= div_cnt + DW'(1);
    end
  end

  // Frame snapshot: every digit of one scan frame comes from the same sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      power_q    <= 1'b0;
      snap_all   <= 6'd0;
      snap_now   <= 6'd0;
      snap_model <= 3'd0;
      snap_water <= 4'd0;
    end else begin
      power_q <= power_led;
      if (load_snap) begin
        snap_all   <= time_all;
        snap_now   <= time_now;
        snap_model <= model_now;
        snap_water <= water_level;
      end
    end
  end

  // The digit latched at a wrap is the one the index names before it advances.
  always_comb begin
    next_an  = 8'h01 << digit_idx;
    next_seg = 8'h00;
    case (digit_idx)
      3'd7: next_seg = seg_code(4'(snap_all / 6'd10));
      3'd6: next_seg = seg_code(4'(snap_all % 6'd10));
      3'd5: next_seg = seg_code(4'(snap_now / 6'd10));
      3'd4: next_seg = seg_code(4'(snap_now % 6'd10));
      3'd3: next_an  = 8'h00;
      3'd2: next_seg = (snap_model >= 3'd6) ? 8'h40 : seg_code({1'b0, snap_model});
      3'd1: begin
        if (snap_water >= 4'd10) next_seg = seg_code(4'd1);
        else                     next_an  = 8'h00;
      end
      default: next_seg = seg_code((snap_water >= 4'd10) ? (snap_water - 4'd10) : snap_water);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !power_led) begin
      an_q  <= 8'h00;
      seg_q <= 8'h00;
    end else if (wrap) begin
      an_q  <= next_an;
      seg_q <= next_seg;
    end
  end

  assign seg = seg_q;

`ifdef TIME_DISPLAY_BLINK_EN
  logic [2:0] sec_sync;
  logic       blink_phase;
  logic       blank_time;

  // sec_sync[1:0] resynchronise clk_sec; sec_sync[2] only remembers the last level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_sync    <= 3'b000;
      blink_phase <= 1'b0;
    end else begin
      sec_sync <= {sec_sync[1:0], clk_sec};
      if (sec_sync[1] && !sec_sync[2]) blink_phase <= ~blink_phase;
    end
  end

  assign blank_time = power_led && !start_led && blink_phase;
  assign an         = blank_time ? {4'h0, an_q[3:0]} : an_q;
`else
  logic [1:0] unused_inputs;
  assign unused_inputs = {clk_sec, start_led};
  assign an            = an_q;
`endif

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display with SCAN_DIV=4 (one digit every 4 clk cycles).
module tb_time_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_sec;
  logic       power_led;
  logic       start_led;
  logic [2:0] model_now;
  logic [3:0] water_level;
  logic [5:0] time_now;
  logic [5:0] time_all;
  logic [7:0] an;
  logic [7:0] seg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  time_display #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_sec     (clk_sec),
    .power_led   (power_led),
    .start_led   (start_led),
    .model_now   (model_now),
    .water_level (water_level),
    .time_now    (time_now),
    .time_all    (time_all),
    .an          (an),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Wait for the next divider wrap and check the digit it latched.
  task automatic next_digit(input string tag, input logic [7:0] exp_an, input logic [7:0] exp_seg);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, "_an"}, an, exp_an);
    check({tag, "_seg"}, seg, exp_seg);
  endtask

  task automatic one_cycle(input string tag, input logic [7:0] exp_an, input logic [7:0] exp_seg);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_an"}, an, exp_an);
    check({tag, "_seg"}, seg, exp_seg);
  endtask

`ifdef TIME_DISPLAY_BLINK_EN
  task automatic sec_period(input string tag, input logic exp_dark);
    logic hi = 1'b0;
    logic lo = 1'b0;
    clk_sec = 1'b1;
    for (int i = 0; i < 128; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 63) clk_sec = 1'b0;
      if (i >= 8) begin
        hi = hi | (|an[7:4]);
        lo = lo | (|an[2:0]);
      end
    end
    check({tag, "_hi"}, {7'd0, hi}, {7'd0, !exp_dark});
    check({tag, "_lo"}, {7'd0, lo}, 8'd1);
  endtask
`endif

  initial begin
    reset       = 1'b1;
    clk_sec     = 1'b0;
    power_led   = 1'b1;
    start_led   = 1'b1;
    model_now   = 3'd0;
    water_level = 4'd3;
    time_now    = 6'd11;
    time_all    = 6'd29;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", an, 8'h00);
    check("rst_seg", seg, 8'h00);
    reset = 1'b0;

    // First digit appears exactly 4 cycles after release.
    for (int i = 0; i < 3; i++) one_cycle("pre_wrap", 8'h00, 8'h00);
    one_cycle("f1_d0", 8'h01, 8'h4F);
    next_digit("f1_d1", 8'h00, 8'h00);
    next_digit("f1_d2", 8'h04, 8'h3F);
    next_digit("f1_d3", 8'h00, 8'h00);
    next_digit("f1_d4", 8'h10, 8'h06);
    next_digit("f1_d5", 8'h20, 8'h06);
    next_digit("f1_d6", 8'h40, 8'h6F);
    next_digit("f1_d7", 8'h80, 8'h5B);

    // Mid-frame change of time_all waits for the 7->0 snapshot.
    next_digit("f2_d0", 8'h01, 8'h4F);
    next_digit("f2_d1", 8'h00, 8'h00);
    next_digit("f2_d2", 8'h04, 8'h3F);
    time_all = 6'd63;
    next_digit("f2_d3", 8'h00, 8'h00);
    next_digit("f2_d4", 8'h10, 8'h06);
    next_digit("f2_d5", 8'h20, 8'h06);
    next_digit("f2_d6", 8'h40, 8'h6F);
    next_digit("f2_d7", 8'h80, 8'h5B);
    model_now   = 3'd6;
    water_level = 4'd12;

    next_digit("f3_d0", 8'h01, 8'h4F);
    next_digit("f3_d1", 8'h00, 8'h00);
    next_digit("f3_d2", 8'h04, 8'h3F);
    next_digit("f3_d3", 8'h00, 8'h00);
    next_digit("f3_d4", 8'h10, 8'h06);
    next_digit("f3_d5", 8'h20, 8'h06);
    next_digit("f3_d6", 8'h40, 8'h4F);
    next_digit("f3_d7", 8'h80, 8'h7D);

    next_digit("f4_d0", 8'h01, 8'h5B);
    next_digit("f4_d1", 8'h02, 8'h06);
    next_digit("f4_d2", 8'h04, 8'h40);

    // Power drop mid-frame; time_now changed while dark reloads on power return.
    power_led = 1'b0;
    time_now  = 6'd47;
    one_cycle("dark_1", 8'h00, 8'h00);
    @(posedge clk);
    one_cycle("dark_3", 8'h00, 8'h00);
    power_led = 1'b1;
    one_cycle("f4_d3", 8'h00, 8'h00);
    next_digit("f4_d4", 8'h10, 8'h07);
    next_digit("f4_d5", 8'h20, 8'h66);
    next_digit("f4_d6", 8'h40, 8'h4F);
    next_digit("f4_d7", 8'h80, 8'h7D);

    // Reset in the middle of a digit restarts the scan at index 0.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    one_cycle("mid_rst_1", 8'h00, 8'h00);
    one_cycle("mid_rst_2", 8'h00, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) one_cycle("rel_wait", 8'h00, 8'h00);
    one_cycle("rel_d0", 8'h01, 8'h5B);

`ifdef TIME_DISPLAY_BLINK_EN
    start_led = 1'b0;
    sec_period("blink_p1", 1'b1);
    sec_period("blink_p2", 1'b0);
    sec_period("blink_p3", 1'b1);
    start_led = 1'b1;
    sec_period("run_p4", 1'b0);
    sec_period("run_p5", 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
